// File: rtl/axi_node_cfg_pkg.sv
// Shared definitions for the AXI node configuration bank:
// address map, control/status bit positions, commit FSM states.
package axi_node_cfg_pkg;

  localparam logic [11:0] START_BASE = 12'h000;
  localparam logic [11:0] END_BASE   = 12'h400;
  localparam logic [11:0] VALID_BASE = 12'h800;
  localparam logic [11:0] CONN_BASE  = 12'h900;
  localparam logic [11:0] CTRL_ADDR  = 12'hC00;
  localparam logic [11:0] STAT_ADDR  = 12'hC04;

  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_LOCK   = 1;
  localparam int CTRL_REVERT = 2;

  localparam int ST_PEND = 0;
  localparam int ST_LOCK = 1;
  localparam int ST_RERR = 2;
  localparam int ST_TMO  = 3;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    CHECK
  } state_e;

  typedef enum logic [2:0] {
    B_START,
    B_END,
    B_VALID,
    B_CONN,
    B_CTRL,
    B_STAT,
    B_NONE
  } bank_e;

  function automatic bank_e decode_bank(input logic [11:0] a);
    bank_e b;
    unique case (1'b1)
      a[11:10] == START_BASE[11:10]: b = B_START;
      a[11:10] == END_BASE[11:10]:   b = B_END;
      a[11:8] == VALID_BASE[11:8]:   b = B_VALID;
      a[11:8] == CONN_BASE[11:8]:    b = B_CONN;
      a[11:2] == CTRL_ADDR[11:2]:    b = B_CTRL;
      a[11:2] == STAT_ADDR[11:2]:    b = B_STAT;
      default:                       b = B_NONE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/axi_node_cfg_rule_check.sv
// Range check over the shadow rules: every valid entry
// must satisfy START <= END (unsigned).
module axi_node_cfg_rule_check #(
  parameter int N_ENT = 64
) (
  input  logic [N_ENT-1:0][31:0] start_i,
  input  logic [N_ENT-1:0][31:0] end_i,
  input  logic [N_ENT-1:0]       valid_i,
  output logic                   pass_o
);

  always_comb begin
    pass_o = 1'b1;
    for (int i = 0; i < N_ENT; i++) begin
      if (valid_i[i] && (start_i[i] > end_i[i])) begin
        pass_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_node_cfg_regs.sv
// APB shadow/active configuration bank for the AXI node decoder
// with guarded commit, lock, revert and one-wait-state access.
module axi_node_cfg_regs
  import axi_node_cfg_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32,
  parameter int N_REGION_MAX   = 4,
  parameter int N_MASTER_PORT  = 16,
  parameter int N_SLAVE_PORT   = 16,
  parameter int COMMIT_TIMEOUT = 1024
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR_i,
  input  logic [APB_DATA_WIDTH-1:0] PWDATA_i,
  input  logic PWRITE_i,
  input  logic PSEL_i,
  input  logic PENABLE_i,
  output logic [APB_DATA_WIDTH-1:0] PRDATA_o,
  output logic PREADY_o,
  output logic PSLVERR_o,
  input  logic node_idle_i,
  input  logic [N_REGION_MAX*N_MASTER_PORT*32-1:0] init_START_ADDR_i,
  input  logic [N_REGION_MAX*N_MASTER_PORT*32-1:0] init_END_ADDR_i,
  input  logic [N_REGION_MAX*N_MASTER_PORT-1:0] init_valid_rule_i,
  input  logic [N_SLAVE_PORT*N_MASTER_PORT-1:0] init_connectivity_map_i,
  output logic [N_REGION_MAX*N_MASTER_PORT*32-1:0] START_ADDR_o,
  output logic [N_REGION_MAX*N_MASTER_PORT*32-1:0] END_ADDR_o,
  output logic [N_REGION_MAX*N_MASTER_PORT-1:0] valid_rule_o,
  output logic [N_SLAVE_PORT*N_MASTER_PORT-1:0] connectivity_map_o,
  output logic cfg_update_o,
  output logic irq_o
);

  localparam int NM = N_MASTER_PORT;
  localparam int NR = N_REGION_MAX;
  localparam int NS = N_SLAVE_PORT;
  localparam int NE = NR * NM;
  localparam int EW = (NE > 1) ? $clog2(NE) : 1;
  localparam int RW = (NR > 1) ? $clog2(NR) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int TW = $clog2(COMMIT_TIMEOUT + 1);

  typedef logic [NE-1:0][31:0] addr_arr_t;
  typedef logic [NR-1:0][NM-1:0] valid_arr_t;
  typedef logic [NS-1:0][NM-1:0] conn_arr_t;

  addr_arr_t  sh_start_q, sh_start_d, sh_end_q, sh_end_d;
  addr_arr_t  ac_start_q, ac_start_d, ac_end_q, ac_end_d;
  valid_arr_t sh_valid_q, sh_valid_d, ac_valid_q, ac_valid_d;
  conn_arr_t  sh_conn_q, sh_conn_d, ac_conn_q, ac_conn_d;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic init_pend_q, init_pend_d;
  logic acc_q, acc_d;
  logic err_q, err_d;
  logic locked_q, locked_d;
  logic rerr_q, rerr_d;
  logic tmo_q, tmo_d;
  logic upd_q, upd_d;

  logic [11:0]   a;
  logic [EW-1:0] ent;
  logic [RW-1:0] ri;
  logic [SW-1:0] si;
  bank_e         bank;
  logic [31:0]   rd;
  logic [31:0]   status;
  logic er, pend, ent_ok, rgn_ok, slv_ok;
  logic access, wr_go, commit_go, pass;
  logic unused_addr;

  assign a      = PADDR_i[11:0];
  assign ent    = a[EW+1:2];
  assign ri     = a[RW+1:2];
  assign si     = a[SW+1:2];
  assign bank   = decode_bank(a);
  assign pend   = (state_q != IDLE);
  assign ent_ok = 32'(a[9:2]) < NE;
  assign rgn_ok = 32'(a[7:2]) < NR;
  assign slv_ok = 32'(a[7:2]) < NS;
  assign access = PSEL_i & PENABLE_i;
  assign unused_addr = ^PADDR_i[1:0];

  axi_node_cfg_rule_check #(
    .N_ENT(NE)
  ) u_rule_check (
    .start_i(sh_start_q),
    .end_i  (sh_end_q),
    .valid_i(sh_valid_q),
    .pass_o (pass)
  );

  always_comb begin
    status = '0;
    status[ST_PEND] = pend;
    status[ST_LOCK] = locked_q;
    status[ST_RERR] = rerr_q;
    status[ST_TMO]  = tmo_q;
    status[15:8]    = cnt_q;
  end

  // Access decode: a locked or pending bank refuses content writes.
  always_comb begin
    rd = '0;
    er = 1'b0;
    unique case (bank)
      B_START: begin
        er = !ent_ok | (PWRITE_i & (locked_q | pend));
        rd = sh_start_q[ent];
      end
      B_END: begin
        er = !ent_ok | (PWRITE_i & (locked_q | pend));
        rd = sh_end_q[ent];
      end
      B_VALID: begin
        er = !rgn_ok | (PWRITE_i & (locked_q | pend));
        rd = 32'(sh_valid_q[ri]);
      end
      B_CONN: begin
        er = !slv_ok | (PWRITE_i & (locked_q | pend));
        rd = 32'(sh_conn_q[si]);
      end
      B_CTRL: begin
        er = PWRITE_i & (locked_q | (pend &
             (PWDATA_i[CTRL_COMMIT] | PWDATA_i[CTRL_REVERT])));
        rd[CTRL_LOCK] = locked_q;
      end
      B_STAT: rd = status;
      default: er = 1'b1;
    endcase
    if (er) rd = '0;
  end

  always_comb begin
    sh_start_d  = sh_start_q;
    sh_end_d    = sh_end_q;
    sh_valid_d  = sh_valid_q;
    sh_conn_d   = sh_conn_q;
    ac_start_d  = ac_start_q;
    ac_end_d    = ac_end_q;
    ac_valid_d  = ac_valid_q;
    ac_conn_d   = ac_conn_q;
    state_d     = state_q;
    timer_d     = timer_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    init_pend_d = init_pend_q;
    acc_d       = 1'b0;
    err_d       = err_q;
    locked_d    = locked_q;
    rerr_d      = rerr_q;
    tmo_d       = tmo_q;
    upd_d       = 1'b0;
    commit_go   = 1'b0;
    wr_go = !init_pend_q & access & acc_q & PWRITE_i & !err_q;

    if (init_pend_q) begin
      sh_start_d  = init_START_ADDR_i;
      sh_end_d    = init_END_ADDR_i;
      sh_valid_d  = init_valid_rule_i;
      sh_conn_d   = init_connectivity_map_i;
      ac_start_d  = init_START_ADDR_i;
      ac_end_d    = init_END_ADDR_i;
      ac_valid_d  = init_valid_rule_i;
      ac_conn_d   = init_connectivity_map_i;
      init_pend_d = 1'b0;
    end else if (access && !acc_q) begin
      acc_d   = 1'b1;
      rdata_d = PWRITE_i ? '0 : rd;
      err_d   = er;
    end

    if (wr_go) begin
      unique case (bank)
        B_START: sh_start_d[ent] = PWDATA_i;
        B_END:   sh_end_d[ent]   = PWDATA_i;
        B_VALID: sh_valid_d[ri]  = PWDATA_i[NM-1:0];
        B_CONN:  sh_conn_d[si]   = PWDATA_i[NM-1:0];
        B_CTRL: begin
          if (PWDATA_i[CTRL_LOCK]) locked_d = 1'b1;
          if (PWDATA_i[CTRL_REVERT]) begin
            sh_start_d = ac_start_q;
            sh_end_d   = ac_end_q;
            sh_valid_d = ac_valid_q;
            sh_conn_d  = ac_conn_q;
          end
          commit_go = PWDATA_i[CTRL_COMMIT];
        end
        B_STAT: begin
          if (PWDATA_i[ST_RERR]) rerr_d = 1'b0;
          if (PWDATA_i[ST_TMO])  tmo_d  = 1'b0;
        end
        default: ;
      endcase
    end

    unique case (state_q)
      IDLE: begin
        if (commit_go) begin
          state_d = PENDING;
          timer_d = '0;
        end
      end
      PENDING: begin
        if (node_idle_i) begin
          state_d = CHECK;
        end else if (timer_q == TW'(COMMIT_TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      CHECK: begin
        if (pass) begin
          ac_start_d = sh_start_q;
          ac_end_d   = sh_end_q;
          ac_valid_d = sh_valid_q;
          ac_conn_d  = sh_conn_q;
          upd_d      = 1'b1;
          cnt_d      = cnt_q + 8'd1;
        end else begin
          rerr_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sh_start_q  <= '0;
      sh_end_q    <= '0;
      sh_valid_q  <= '0;
      sh_conn_q   <= '0;
      ac_start_q  <= '0;
      ac_end_q    <= '0;
      ac_valid_q  <= '0;
      ac_conn_q   <= '0;
      state_q     <= IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      init_pend_q <= 1'b1;
      acc_q       <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
      rerr_q      <= 1'b0;
      tmo_q       <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      sh_start_q  <= sh_start_d;
      sh_end_q    <= sh_end_d;
      sh_valid_q  <= sh_valid_d;
      sh_conn_q   <= sh_conn_d;
      ac_start_q  <= ac_start_d;
      ac_end_q    <= ac_end_d;
      ac_valid_q  <= ac_valid_d;
      ac_conn_q   <= ac_conn_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      init_pend_q <= init_pend_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
      rerr_q      <= rerr_d;
      tmo_q       <= tmo_d;
      upd_q       <= upd_d;
    end
  end

  // Until the first clock the active bank is not loaded yet.
  assign START_ADDR_o = init_pend_q ? init_START_ADDR_i : ac_start_q;
  assign END_ADDR_o   = init_pend_q ? init_END_ADDR_i : ac_end_q;
  assign valid_rule_o = init_pend_q ? init_valid_rule_i : ac_valid_q;
  assign connectivity_map_o =
    init_pend_q ? init_connectivity_map_i : ac_conn_q;

  assign PRDATA_o     = rdata_q;
  assign PREADY_o     = acc_q;
  assign PSLVERR_o    = acc_q & err_q;
  assign cfg_update_o = upd_q;
  assign irq_o        = rerr_q | tmo_q;

endmodule
